// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC trigger/capture block: FSM states, edge
// selection codes and a small state-class helper.
package adc_cap_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE_FILL  = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST_FILL = 3'd3,
    S_DONE      = 3'd4
  } cap_state_e;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  function automatic logic is_busy(input cap_state_e s);
    return (s == S_PRE_FILL) || (s == S_WAIT_TRIG) || (s == S_POST_FILL);
  endfunction

endpackage

// File: rtl/adc_trig_capture_if.sv
// Sample, trigger-control, status and readout signals of the capture block.
// master = controller/host side, slave = capture block.
interface adc_trig_capture_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  adc_valid;
  logic                  arm;
  logic                  force_trig;
  logic                  trig_edge;
  logic [DATA_WIDTH-1:0] trig_level;
  logic [ADDR_WIDTH-1:0] pre_depth;
  logic                  busy;
  logic                  triggered;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output adc_data, adc_valid, arm, force_trig, trig_edge, trig_level, pre_depth,
           rd_en, rd_addr,
    input  busy, triggered, done, rd_data, rd_valid
  );

  modport slave (
    input  adc_data, adc_valid, arm, force_trig, trig_edge, trig_level, pre_depth,
           rd_en, rd_addr,
    output busy, triggered, done, rd_data, rd_valid
  );
endinterface

// File: rtl/adc_trig_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// The read register holds its value whenever rd_en is low.
module capture_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk_in) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/adc_trig_capture.sv
// Triggered circular-buffer capture of one ADC channel with programmable
// pre-trigger depth; the finished record is frozen for host readout.
module adc_trig_capture
  import adc_cap_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk_in,
  input  logic                RST,
  adc_trig_capture_if.slave   cap
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  cap_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [CW-1:0]         post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] trig_ptr_q, trig_ptr_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  prev_valid_q, prev_valid_d;
  logic                  triggered_q, triggered_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  wr_en;
  logic                  rise_hit, fall_hit, trig_hit;
  logic [CW-1:0]         post_target;
  logic                  rd_fire;
  logic [ADDR_WIDTH-1:0] rd_phys;

  // post_target is DEPTH when pre_q == 0, hence the extra counter bit.
  assign post_target = CW'(DEPTH) - {1'b0, pre_q};

  assign rise_hit = prev_valid_q && (prev_q <  cap.trig_level) && (cap.adc_data >= cap.trig_level);
  assign fall_hit = prev_valid_q && (prev_q >= cap.trig_level) && (cap.adc_data <  cap.trig_level);
  assign trig_hit = cap.adc_valid &&
                    (cap.force_trig || ((cap.trig_edge == EDGE_FALL) ? fall_hit : rise_hit));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    post_cnt_d   = post_cnt_q;
    pre_d        = pre_q;
    trig_ptr_d   = trig_ptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    triggered_d  = triggered_q;
    done_d       = done_q;
    wr_en        = 1'b0;

    if (cap.arm) begin
      wr_ptr_d     = '0;
      cnt_d        = '0;
      prev_valid_d = 1'b0;
      triggered_d  = 1'b0;
      done_d       = 1'b0;
      pre_d        = cap.pre_depth;
      state_d      = (cap.pre_depth == '0) ? S_WAIT_TRIG : S_PRE_FILL;
    end else if (is_busy(state_q) && cap.adc_valid) begin
      wr_en        = 1'b1;
      wr_ptr_d     = wr_ptr_q + 1'b1;
      prev_d       = cap.adc_data;
      prev_valid_d = 1'b1;
      case (state_q)
        S_PRE_FILL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == pre_q) state_d = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          if (trig_hit) begin
            trig_ptr_d  = wr_ptr_q;
            triggered_d = 1'b1;
            post_cnt_d  = CW'(1);
            // With pre_q == DEPTH-1 the trigger sample alone completes the record.
            if (post_target == CW'(1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_POST_FILL;
            end
          end
        end
        S_POST_FILL: begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_d == post_target) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_fire    = cap.rd_en && (state_q == S_DONE);
  assign rd_valid_d = rd_fire;
  // Host addresses are relative to the oldest kept sample.
  assign rd_phys    = trig_ptr_q - pre_q + cap.rd_addr;

  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      post_cnt_q   <= '0;
      pre_q        <= '0;
      trig_ptr_q   <= '0;
      prev_valid_q <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      post_cnt_q   <= post_cnt_d;
      pre_q        <= pre_d;
      trig_ptr_q   <= trig_ptr_d;
      prev_valid_q <= prev_valid_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    prev_q <= prev_d;
  end

  capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_in  (clk_in),
    .rst     (RST),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (cap.adc_data),
    .rd_en   (rd_fire),
    .rd_addr (rd_phys),
    .rd_data (cap.rd_data)
  );

  assign cap.busy      = is_busy(state_q);
  assign cap.triggered = triggered_q;
  assign cap.done      = done_q;
  assign cap.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_adc_trig_capture.sv
// Bench for adc_trig_capture (DEPTH = 16): the reference model keeps every
// accepted sample of a capture in a list and cuts the record out of it.
module tb_adc_trig_capture;
  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk_in = 1'b0;
  logic RST;
  always #5 clk_in = ~clk_in;

  adc_trig_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  adc_trig_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_in (clk_in),
    .RST    (RST),
    .cap    (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int hist[$];
  int m_pre, m_tidx, m_lvl;
  bit m_busy, m_done, m_edge;
  int got[DEPTH];
  int last_rd;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One accepted sample while a capture is running.
  function automatic void model_sample(input int d, input bit f);
    int idx;
    bit hit;
    int p;
    hist.push_back(d);
    idx = hist.size() - 1;
    if (m_tidx < 0 && idx >= m_pre) begin
      hit = f;
      if (idx > 0) begin
        p = hist[idx-1];
        if (!m_edge) hit = hit | (p <  m_lvl && d >= m_lvl);
        else         hit = hit | (p >= m_lvl && d <  m_lvl);
      end
      if (hit) m_tidx = idx;
    end
    if (m_tidx >= 0 && hist.size() == m_tidx + DEPTH - m_pre) begin
      m_done = 1'b1;
      m_busy = 1'b0;
    end
  endfunction

  function automatic int gen(input int mode, input int k);
    int r;
    case (mode)
      0:       r = k % 256;
      1:       r = int'(2047.0 + 1800.0 * $sin(6.2831853 * real'(k) / 29.0));
      2:       r = 7 + k;
      default: r = int'($urandom_range(0, 4095));
    endcase
    return r;
  endfunction

  task automatic step(input int d, input bit v, input bit f);
    @(negedge clk_in);
    bus.arm        = 1'b0;
    bus.rd_en      = 1'b0;
    bus.adc_data   = DW'(d);
    bus.adc_valid  = v;
    bus.force_trig = f;
    @(posedge clk_in); #1;
    if (v && m_busy) model_sample(d, f);
    chk("busy", bus.busy, int'(m_busy));
    chk("triggered", bus.triggered, int'(m_tidx >= 0));
    chk("done", bus.done, int'(m_done));
  endtask

  task automatic do_arm(input int pre, input int lvl, input bit e);
    @(negedge clk_in);
    bus.arm        = 1'b1;
    bus.rd_en      = 1'b0;
    bus.pre_depth  = AW'(pre);
    bus.trig_level = DW'(lvl);
    bus.trig_edge  = e;
    bus.adc_valid  = 1'($urandom_range(0, 1));
    bus.adc_data   = DW'($urandom);
    bus.force_trig = 1'b0;
    @(posedge clk_in); #1;
    hist.delete();
    m_pre = pre; m_tidx = -1; m_done = 1'b0; m_busy = 1'b1; m_lvl = lvl; m_edge = e;
    chk("arm_busy", bus.busy, 1);
    chk("arm_trig", bus.triggered, 0);
    chk("arm_done", bus.done, 0);
  endtask

  // vmode: 0 gap-free, 1 alternating, 2 random gaps. stop_post > 0 stops
  // once that many samples past the trigger have been accepted.
  task automatic run_capture(input string tag, input int mode, input int vmode,
                             input int fmode, input int stop_post);
    int k = 0;
    int n = 0;
    bit v, f;
    while (!m_done && n < 2000 &&
           !(stop_post > 0 && m_tidx >= 0 && hist.size() >= m_tidx + 1 + stop_post)) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      case (fmode)
        1:       f = (k == 0);
        2:       f = ($urandom_range(0, 63) == 0);
        default: f = 1'b0;
      endcase
      step(gen(mode, k), v, f);
      if (v) k++;
      n++;
    end
    if (stop_post == 0) chk({tag, "_complete"}, bus.done, 1);
  endtask

  task automatic readout(input string tag);
    int base;
    int e;
    if (!m_done) return;
    base = m_tidx - m_pre;
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk_in);
      bus.arm       = 1'b0;
      bus.adc_valid = 1'b0;
      bus.rd_en     = 1'b1;
      bus.rd_addr   = AW'(a);
      @(posedge clk_in); #1;
      e = hist[base + a];
      got[a] = int'(bus.rd_data);
      chk({tag, "_rd_valid"}, bus.rd_valid, 1);
      chk({tag, "_rd_data"}, bus.rd_data, e);
      last_rd = e;
    end
    @(negedge clk_in);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    bus.adc_data = '0; bus.adc_valid = 1'b0; bus.arm = 1'b0; bus.force_trig = 1'b0;
    bus.trig_edge = 1'b0; bus.trig_level = '0; bus.pre_depth = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    m_busy = 1'b0; m_done = 1'b0; m_tidx = -1; m_pre = 0; m_lvl = 0; m_edge = 1'b0;
    last_rd = 0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_triggered", bus.triggered, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    @(negedge clk_in);
    RST = 1'b0;

    // Ramp, rising edge at 100, four pre-trigger samples.
    do_arm(4, 100, 1'b0);
    run_capture("t1", 0, 0, 0, 0);
    readout("t1");
    for (int a = 0; a < DEPTH; a++) chk("t1_record", got[a], 96 + a);

    // Same capture with a sample gap every other cycle.
    do_arm(4, 100, 1'b0);
    run_capture("t6", 0, 1, 0, 0);
    readout("t6");
    for (int a = 0; a < DEPTH; a++) chk("t6_record", got[a], 96 + a);

    // Read request while waiting for a trigger is ignored.
    do_arm(2, 4000, 1'b0);
    for (int k = 0; k < 4; k++) step(k, 1'b1, 1'b0);
    @(negedge clk_in);
    bus.adc_valid = 1'b0; bus.rd_en = 1'b1; bus.rd_addr = AW'(3);
    @(posedge clk_in); #1;
    chk("wait_rd_valid", bus.rd_valid, 0);
    chk("wait_rd_hold", bus.rd_data, last_rd);

    // Falling edge at mid-scale on a sine.
    do_arm(8, 2048, 1'b1);
    run_capture("t2", 1, 2, 0, 0);
    readout("t2");
    chk("t2_trig_below", int'(got[8] < 2048), 1);
    chk("t2_prev_above", int'(got[7] >= 2048), 1);

    // No pre-trigger samples, forced trigger on the first valid sample.
    do_arm(0, 4095, 1'b0);
    run_capture("t3", 2, 2, 1, 0);
    readout("t3");
    chk("t3_addr0", got[0], 7);
    chk("t3_addr15", got[15], 22);

    // Maximum pre-trigger depth: the trigger sample closes the record.
    do_arm(15, 100, 1'b0);
    run_capture("t4", 0, 0, 0, 0);
    readout("t4");
    chk("t4_addr15", got[15], 100);
    chk("t4_addr0", got[0], 85);

    // Re-arm in the middle of the post-trigger phase.
    do_arm(4, 100, 1'b0);
    run_capture("t5a", 0, 0, 0, 3);
    do_arm(6, 50, 1'b0);
    run_capture("t5b", 0, 2, 0, 0);
    readout("t5b");
    chk("t5_addr6", got[6], 50);

    // Random captures.
    for (int r = 0; r < 6; r++) begin
      do_arm(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 4095)),
             1'($urandom_range(0, 1)));
      run_capture("rnd", 3, 2, 2, 0);
      readout("rnd");
    end

    // arm and reset in the same cycle: reset wins.
    do_arm(3, 100, 1'b0);
    run_capture("t5c", 0, 0, 0, 0);
    @(negedge clk_in);
    bus.arm = 1'b1; bus.pre_depth = AW'(3); RST = 1'b1; bus.adc_valid = 1'b1;
    @(posedge clk_in); #1;
    hist.delete(); m_busy = 1'b0; m_done = 1'b0; m_tidx = -1;
    chk("armrst_busy", bus.busy, 0);
    chk("armrst_triggered", bus.triggered, 0);
    chk("armrst_done", bus.done, 0);
    @(negedge clk_in);
    RST = 1'b0; bus.arm = 1'b0;
    for (int k = 0; k < 4; k++) step(200 + k, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
